lsu: RTL and testbench

- Load/store unit in the EX->MEM boundary, directly downstream of the ALU.
- Consumes the effective address computed by the ALU (rs1+imm add result) plus store data and funct3.
- Performs RV32I byte/half/word accesses to a word-organised data memory over a req/gnt/rvalid handshake.
- Splits misaligned accesses into two aligned word accesses and returns load data sign/zero-extended for writeback.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu.sv | 194 +++++++++++++++++++
 tb/tb_lsu.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the byte-mask helper used for store lane generation.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_RESP0,
        ST_REQ1,
        ST_RESP1,
        ST_DONE
    } lsu_state_t;

    // Unshifted byte mask for an access size (funct3[1:0]).
    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-organised data memory bus: req/gnt request phase, rvalid response phase.
interface lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DM_ADDR_W  = 9
) ();

    logic                  mem_req;
    logic                  mem_gnt;
    logic                  mem_we;
    logic [DM_ADDR_W-1:0]  mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store mask/data shifting over a two-word window,
// and load byte/half/word extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [1:0]              st_size_i,
    input  logic [1:0]              st_off_i,
    input  logic [DATA_WIDTH-1:0]   st_wdata_i,
    output logic [7:0]              st_be_c_o,
    output logic [2*DATA_WIDTH-1:0] st_wdata_c_o,
    input  logic [2:0]              ld_funct3_i,
    input  logic [1:0]              ld_off_i,
    input  logic [2*DATA_WIDTH-1:0] ld_rdata_i,
    output logic [DATA_WIDTH-1:0]   ld_data_c_o
);

    localparam int unsigned SH_W = 5;

    logic [SH_W-1:0]       st_sh;
    logic [SH_W-1:0]       ld_sh;
    logic [DATA_WIDTH-1:0] ld_win;

    assign st_sh        = {st_off_i, 3'b000};
    assign st_be_c_o    = 8'(base_mask(st_size_i)) << st_off_i;
    assign st_wdata_c_o = (2*DATA_WIDTH)'(st_wdata_i) << st_sh;

    assign ld_sh  = {ld_off_i, 3'b000};
    assign ld_win = DATA_WIDTH'(ld_rdata_i >> ld_sh);

    // Narrow loads extend from the low lanes of the realigned window.
    always_comb begin
        ld_data_c_o = '0;
        case (ld_funct3_i)
            F3_B:  ld_data_c_o = {{(DATA_WIDTH-8){ld_win[7]}}, ld_win[7:0]};
            F3_H:  ld_data_c_o = {{(DATA_WIDTH-16){ld_win[15]}}, ld_win[15:0]};
            F3_W:  ld_data_c_o = ld_win;
            F3_BU: ld_data_c_o = {{(DATA_WIDTH-8){1'b0}}, ld_win[7:0]};
            F3_HU: ld_data_c_o = {{(DATA_WIDTH-16){1'b0}}, ld_win[15:0]};
            default: ld_data_c_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one EX-stage access, performs one or two
// aligned word transactions on the memory bus, and returns extended load data.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DM_ADDR_W  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [DM_ADDR_W-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_err,
    lsu_if.master                 mem
);

    localparam int unsigned WORD_W = DM_ADDR_W - 2;

    lsu_state_t            state_q, state_d;
    logic                  load_q, load_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  split_q, split_d;
    logic [3:0]            be1_q, be1_d;
    logic [DATA_WIDTH-1:0] wdata1_q, wdata1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic                  mem_we_q, mem_we_d;
    logic [DM_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
    logic                  out_err_q, out_err_d;

    logic                    store_c;
    logic                    illegal_c;
    logic                    misaligned_c;
    logic [7:0]              st_be_c;
    logic [2*DATA_WIDTH-1:0] st_wdata_c;
    logic [2*DATA_WIDTH-1:0] ld_rdata_c;
    logic [DATA_WIDTH-1:0]   ld_data_c;

    // Load wins when both request flags are set.
    assign store_c   = in_store & ~in_load;
    assign illegal_c = (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11) ||
                       (store_c && in_funct3[2]);
    assign misaligned_c = ((in_funct3[1:0] == 2'b01) && (in_addr[1:0] == 2'b11)) ||
                          ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

    assign ld_rdata_c = (state_q == ST_RESP1) ? {mem.mem_rdata, rdata0_q}
                                              : {{DATA_WIDTH{1'b0}}, mem.mem_rdata};

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .st_size_i    (in_funct3[1:0]),
        .st_off_i     (in_addr[1:0]),
        .st_wdata_i   (in_wdata),
        .st_be_c_o    (st_be_c),
        .st_wdata_c_o (st_wdata_c),
        .ld_funct3_i  (funct3_q),
        .ld_off_i     (off_q),
        .ld_rdata_i   (ld_rdata_c),
        .ld_data_c_o  (ld_data_c)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        load_d      = load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        word_d      = word_q;
        split_d     = split_q;
        be1_d       = be1_q;
        wdata1_d    = wdata1_q;
        rdata0_d    = rdata0_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && (in_load || in_store)) begin
                    load_d   = in_load;
                    funct3_d = in_funct3;
                    off_d    = in_addr[1:0];
                    word_d   = in_addr[DM_ADDR_W-1:2];
                    split_d  = in_load ? misaligned_c : (|st_be_c[7:4]);
                    if (illegal_c) begin
                        state_d     = ST_DONE;
                        out_err_d   = 1'b1;
                        out_rdata_d = '0;
                    end else begin
                        state_d     = ST_REQ0;
                        mem_addr_d  = {in_addr[DM_ADDR_W-1:2], 2'b00};
                        mem_we_d    = store_c;
                        mem_be_d    = in_load ? 4'b1111 : st_be_c[3:0];
                        mem_wdata_d = in_load ? '0 : st_wdata_c[DATA_WIDTH-1:0];
                        be1_d       = st_be_c[7:4];
                        wdata1_d    = st_wdata_c[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                end
            end
            ST_REQ0: begin
                if (mem.mem_gnt) state_d = ST_RESP0;
            end
            ST_RESP0: begin
                if (mem.mem_rvalid) begin
                    rdata0_d = mem.mem_rdata;
                    if (split_q) begin
                        state_d     = ST_REQ1;
                        mem_addr_d  = {word_q + WORD_W'(1), 2'b00};
                        mem_be_d    = load_q ? 4'b1111 : be1_q;
                        mem_wdata_d = load_q ? '0 : wdata1_q;
                    end else begin
                        state_d     = ST_DONE;
                        out_err_d   = 1'b0;
                        out_rdata_d = load_q ? ld_data_c : '0;
                    end
                end
            end
            ST_REQ1: begin
                if (mem.mem_gnt) state_d = ST_RESP1;
            end
            ST_RESP1: begin
                if (mem.mem_rvalid) begin
                    state_d     = ST_DONE;
                    out_err_d   = 1'b0;
                    out_rdata_d = load_q ? ld_data_c : '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_q      <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            word_q      <= '0;
            split_q     <= 1'b0;
            be1_q       <= '0;
            wdata1_q    <= '0;
            rdata0_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            word_q      <= word_d;
            split_q     <= split_d;
            be1_q       <= be1_d;
            wdata1_q    <= wdata1_d;
            rdata0_q    <= rdata0_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;
    assign mem.mem_req   = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: behavioural word memory with programmable grant and
// response delays, access log, and hand-computed expected results.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [8:0]  in_addr;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;

    lsu_if #(.DATA_WIDTH(32), .DM_ADDR_W(9)) mif ();

    lsu #(.DATA_WIDTH(32), .DM_ADDR_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_load   (in_load),
        .in_store  (in_store),
        .in_funct3 (in_funct3),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_rdata (out_rdata),
        .out_err   (out_err),
        .mem       (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model state and access log.
    logic [31:0] mem_words [128];
    int          gnt_wait = 0;
    int          rv_wait  = 1;
    int          n_acc    = 0;
    int          req_cyc  = 0;
    int          stab_bad = 0;
    logic [8:0]  acc_addr [8];
    logic [3:0]  acc_be   [8];
    logic [31:0] acc_wd   [8];
    logic        acc_we   [8];

    int          m_wcnt = 0;
    int          m_pcnt = 0;
    bit          m_pend = 0;
    logic [31:0] m_hold;
    logic [6:0]  m_idx;
    logic [8:0]  s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    logic        s_we;

    initial begin : mem_model
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mif.mem_rvalid = 1'b0;
            if (mif.mem_gnt) begin
                mif.mem_gnt = 1'b0;
                m_pend = 1'b1;
                m_pcnt = rv_wait;
            end else if (!m_pend && mif.mem_req) begin
                req_cyc++;
                if (m_wcnt == 0) begin
                    s_addr = mif.mem_addr; s_be = mif.mem_be;
                    s_wd   = mif.mem_wdata; s_we = mif.mem_we;
                end else if (s_addr !== mif.mem_addr || s_be !== mif.mem_be ||
                             s_wd !== mif.mem_wdata || s_we !== mif.mem_we) begin
                    stab_bad++;
                end
                if (m_wcnt == gnt_wait) begin
                    mif.mem_gnt = 1'b1;
                    m_wcnt = 0;
                    if (n_acc < 8) begin
                        acc_addr[n_acc] = mif.mem_addr;
                        acc_be[n_acc]   = mif.mem_be;
                        acc_wd[n_acc]   = mif.mem_wdata;
                        acc_we[n_acc]   = mif.mem_we;
                    end
                    n_acc++;
                    m_idx  = mif.mem_addr[8:2];
                    m_hold = mem_words[m_idx];
                    if (mif.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mif.mem_be[b]) mem_words[m_idx][8*b +: 8] = mif.mem_wdata[8*b +: 8];
                    end
                end else begin
                    m_wcnt++;
                end
            end
            if (m_pend) begin
                m_pcnt--;
                if (m_pcnt <= 0) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = m_hold;
                    m_pend = 1'b0;
                end
            end
        end
    end

    // Issue one access and wait (bounded) for its completion pulse.
    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int rdy_hi, output logic rdy_after);
        lat = 0; rd = 'x; er = 1'bx; rdy_hi = 0; rdy_after = 1'b0;
        n_acc = 0; req_cyc = 0; stab_bad = 0;
        @(negedge clk);
        in_valid = 1'b1; in_load = ld; in_store = st;
        in_funct3 = f3; in_addr = addr; in_wdata = wd;
        @(posedge clk);
        #1 in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
            if (out_valid) begin
                lat = k; rd = out_rdata; er = out_err;
                break;
            end
        end
        @(negedge clk);
        rdy_after = in_ready;
    endtask

    int          lat, rdy_hi, ov_cnt;
    logic [31:0] rd;
    logic        er, rdy_after;

    initial begin
        for (int i = 0; i < 128; i++) mem_words[i] = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_funct3 = '0; in_addr = '0; in_wdata = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_out_err",   32'(out_err),   32'd0);
        chk_eq("rst_out_rdata", out_rdata,      32'd0);
        chk_eq("rst_mem_req",   32'(mif.mem_req), 32'd0);
        chk_eq("rst_mem_be",    32'(mif.mem_be),  32'd0);
        chk_eq("rst_mem_addr",  32'(mif.mem_addr), 32'd0);
        chk_eq("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // in_valid without load/store must be ignored
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk_eq("noop_in_ready", 32'(in_ready), 32'd1);
        chk_eq("noop_mem_req",  32'(mif.mem_req), 32'd0);

        // aligned SW
        gnt_wait = 0; rv_wait = 1;
        do_req(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("sw_lat",   32'(lat), 32'd3);
        chk_eq("sw_nacc",  32'(n_acc), 32'd1);
        chk_eq("sw_addr",  32'(acc_addr[0]), 32'h010);
        chk_eq("sw_be",    32'(acc_be[0]), 32'hF);
        chk_eq("sw_wdata", acc_wd[0], 32'hDEADBEEF);
        chk_eq("sw_we",    32'(acc_we[0]), 32'd1);
        chk_eq("sw_rdata", rd, 32'd0);
        chk_eq("sw_err",   32'(er), 32'd0);
        chk_eq("sw_rdy_busy", 32'(rdy_hi), 32'd0);
        chk_eq("sw_rdy_after", 32'(rdy_after), 32'd1);
        chk_eq("sw_memword", mem_words[4], 32'hDEADBEEF);

        // LB / LBU at byte 3
        mem_words[4] = 32'h80FF7F01;
        do_req(1'b1, 1'b0, 3'b000, 9'h013, 32'h0, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("lb_lat",   32'(lat), 32'd3);
        chk_eq("lb_be",    32'(acc_be[0]), 32'hF);
        chk_eq("lb_we",    32'(acc_we[0]), 32'd0);
        chk_eq("lb_addr",  32'(acc_addr[0]), 32'h010);
        chk_eq("lb_rdata", rd, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 3'b100, 9'h013, 32'h0, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("lbu_rdata", rd, 32'h00000080);

        // misaligned LW, load+store both set counts as load
        mem_words[1] = 32'hAABBCCDD;
        mem_words[2] = 32'h11223344;
        do_req(1'b1, 1'b1, 3'b010, 9'h006, 32'hFFFFFFFF, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("lw_lat",   32'(lat), 32'd5);
        chk_eq("lw_nacc",  32'(n_acc), 32'd2);
        chk_eq("lw_addr0", 32'(acc_addr[0]), 32'h004);
        chk_eq("lw_addr1", 32'(acc_addr[1]), 32'h008);
        chk_eq("lw_we1",   32'(acc_we[1]), 32'd0);
        chk_eq("lw_rdata", rd, 32'h3344AABB);
        chk_eq("lw_word1_untouched", mem_words[1], 32'hAABBCCDD);

        // misaligned SH wrapping to word 0
        mem_words[127] = 32'h12345678;
        mem_words[0]   = 32'h00000000;
        do_req(1'b0, 1'b1, 3'b001, 9'h1FF, 32'h0000BEEF, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("sh_nacc",  32'(n_acc), 32'd2);
        chk_eq("sh_addr0", 32'(acc_addr[0]), 32'h1FC);
        chk_eq("sh_be0",   32'(acc_be[0]), 32'h8);
        chk_eq("sh_wd0",   acc_wd[0], 32'hEF000000);
        chk_eq("sh_addr1", 32'(acc_addr[1]), 32'h000);
        chk_eq("sh_be1",   32'(acc_be[1]), 32'h1);
        chk_eq("sh_wd1",   acc_wd[1], 32'h000000BE);
        chk_eq("sh_mem127", mem_words[127], 32'hEF345678);
        chk_eq("sh_mem0",   mem_words[0], 32'h000000BE);
        chk_eq("sh_rdata",  rd, 32'd0);

        // illegal funct3: load 011, store 100
        do_req(1'b1, 1'b0, 3'b011, 9'h020, 32'h0, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("ill_ld_lat", 32'(lat), 32'd1);
        chk_eq("ill_ld_err", 32'(er), 32'd1);
        chk_eq("ill_ld_req", 32'(req_cyc), 32'd0);
        chk_eq("ill_ld_rdata", rd, 32'd0);
        do_req(1'b0, 1'b1, 3'b100, 9'h020, 32'h55, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("ill_st_err", 32'(er), 32'd1);
        chk_eq("ill_st_req", 32'(req_cyc), 32'd0);

        // LHU with grant held off 3 cycles and response 2 cycles after grant
        mem_words[0] = 32'h80015A5A;
        gnt_wait = 3; rv_wait = 2;
        do_req(1'b1, 1'b0, 3'b101, 9'h002, 32'h0, lat, rd, er, rdy_hi, rdy_after);
        chk_eq("lhu_lat",    32'(lat), 32'd7);
        chk_eq("lhu_rdata",  rd, 32'h00008001);
        chk_eq("lhu_err",    32'(er), 32'd0);
        chk_eq("lhu_stable", 32'(stab_bad), 32'd0);
        chk_eq("lhu_reqcyc", 32'(req_cyc), 32'd4);
        chk_eq("lhu_rdy_busy", 32'(rdy_hi), 32'd0);

        // reset while waiting in RESP0; late rvalid after release is ignored
        gnt_wait = 0; rv_wait = 6;
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 9'h020;
        @(posedge clk);
        #1 in_valid = 1'b0; in_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("pre_rst_addr", 32'(mif.mem_addr), 32'h020);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_addr",  32'(mif.mem_addr), 32'd0);
        chk_eq("mid_rst_be",    32'(mif.mem_be), 32'd0);
        chk_eq("mid_rst_rdata", out_rdata, 32'd0);
        chk_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk_eq("late_rvalid_ignored", 32'(ov_cnt), 32'd0);
        chk_eq("post_rst_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
